stack_core_p: RTL and testbench
===============================

STACK_CORE_P -- requirements
Module: stack_core_p

Interface
REQ-001 Parameter: DATA_W, 16, width of stack entries, register-file entries and memory data/address.
REQ-002 Parameter: DEPTH, 16, number of stack entries (power of two, >= 4).
REQ-003 Parameter: NREGS, 4, number of general registers (power of two, >= 2).
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 op_valid  in  1  operation request.
REQ-007 op_ready  out  1  core can accept an operation this cycle.
REQ-008 op  in  3  0 NOP, 1 PUSH, 2 POP1, 3 POP2, 4 DUP, 5 SWAP, 6 POP2PUSH, 7 reserved (treated as NOP).
REQ-009 push_src  in  2  0 zero, 1 push_in, 2 memory, 3 register file.
REQ-010 push_in  in  DATA_W  external push operand (e.g. ALU result).
REQ-011 reg_addr  in  log2(NREGS)  register-file index for read and write.
REQ-012 reg_we  in  1  write a_out into reg_addr (independent of op).
REQ-013 mem_we  in  1  request memory write of b_out to address a_out.
REQ-014 mem_addr / mem_wdata / mem_wen  out  DATA_W / DATA_W / 1  memory port; mem_addr = a_out, mem_wdata = b_out, mem_wen = mem_we.
REQ-015 mem_rdata  in  DATA_W  memory read data, valid exactly one cycle after mem_addr is presented.
REQ-016 a_out / b_out  out  DATA_W  top and second stack entry, registered.
REQ-017 depth  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-018 empty / full  out  1 / 1  depth == 0 / depth == DEPTH.
REQ-019 err  out  1  sticky overflow/underflow flag (see Configuration).

Function
REQ-020 An operation SHALL be accepted only in a cycle with op_valid && op_ready; its effect on a_out, b_out and depth SHALL be visible the following cycle.
REQ-021 State machine SHALL have two states: IDLE (op_ready = 1) and MEMWAIT (op_ready = 0).
REQ-022 PUSH with push_src != 2 SHALL complete in IDLE in one cycle; PUSH with push_src = 2 SHALL move to MEMWAIT, capture mem_rdata on the next edge, push it and return to IDLE (2-cycle latency).
REQ-023 Register-file read for push_src = 3 SHALL be combinational on reg_addr at the accept cycle; reg_we write SHALL take effect at the next edge, and a same-cycle push from the same register SHALL push the old value.
REQ-024 PUSH: depth+1, new a_out = pushed value, b_out = previous a_out.
REQ-025 POP1: depth-1; POP2: depth-2; a_out/b_out SHALL show the new top two entries.
REQ-026 DUP: push previous a_out; SWAP: exchange a_out and b_out, depth unchanged.
REQ-027 POP2PUSH: pop two then push the push_src value in one cycle (net depth-1); push_src = 2 SHALL use MEMWAIT as in REQ-022.
REQ-028 a_out SHALL read 0 when depth < 1; b_out SHALL read 0 when depth < 2.
REQ-029 Underflow: POP1/SWAP/DUP at depth < needed, POP2/POP2PUSH at depth < 2; overflow: any net-increasing op at depth == DEPTH.
REQ-030 mem_we and reg_we SHALL be honoured in any state, using a_out/b_out of the current cycle.
REQ-031 op_valid in MEMWAIT SHALL be ignored; requester holds the request until op_ready.

Reset
REQ-032 Reset assertion SHALL immediately force IDLE, depth = 0, a_out = b_out = 0, err = 0, op_ready = 1; register file SHALL clear to 0.
REQ-033 Reset during MEMWAIT SHALL abandon the pending push; mem_rdata following release SHALL be ignored.

Configuration
REQ-034 Macro STACK_ERR_TRAP_EN defined: offending over/underflow ops SHALL leave the stack unchanged and set err until reset.
REQ-035 Macro STACK_ERR_TRAP_EN undefined: pointer SHALL wrap modulo DEPTH (depth saturates at 0 / DEPTH for reporting), err SHALL be tied 0.

Verification
REQ-036 Reset, PUSH push_in 0x0011, PUSH 0x0022 -> a_out 0x0022, b_out 0x0011, depth 2.
REQ-037 a_out 0x0005, PUSH push_src 2 -> op_ready 0 one cycle, mem_addr 0x0005, mem_rdata 0xBEEF pushed, a_out 0xBEEF after 2 cycles.
REQ-038 Stack [0x0003,0x0004], SWAP then POP2PUSH push_in 0x0007 -> a_out 0x0003 after SWAP, then a_out 0x0007, depth 1.
REQ-039 reg_we with a_out 0x00AA to reg 2 and same-cycle PUSH src 3 reg 2 -> old value 0x0000 pushed; next PUSH src 3 -> 0x00AA.
REQ-040 STACK_ERR_TRAP_EN: DEPTH+1 pushes -> full 1, err 1, last value not stored; POP1 on empty -> depth stays 0.
REQ-041 Reset asserted mid-MEMWAIT -> depth 0, op_ready 1 immediately, no push after release.

Source files
------------

// File: rtl/stack_core_p.sv
// stack_core_p: hardware operand stack with a two-entry registered head
// (a_out/b_out), a small general register file and a one-cycle-latency
// memory port for pushes from memory.
//
// Build option:
//   STACK_ERR_TRAP_EN  defined   -> over/underflowing ops are dropped and the
//                                   sticky err flag is raised until reset.
//                      undefined -> the stack pointer wraps modulo DEPTH,
//                                   depth saturates at 0 / DEPTH and err reads 0.
module stack_core_p #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int NREGS  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      op_valid,
    output logic                      op_ready,
    input  logic [2:0]                op,
    input  logic [1:0]                push_src,
    input  logic [DATA_W-1:0]         push_in,
    input  logic [$clog2(NREGS)-1:0]  reg_addr,
    input  logic                      reg_we,
    input  logic                      mem_we,
    output logic [DATA_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      mem_wen,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [DATA_W-1:0]         a_out,
    output logic [DATA_W-1:0]         b_out,
    output logic [$clog2(DEPTH):0]    depth,
    output logic                      empty,
    output logic                      full,
    output logic                      err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_PUSH     = 3'd1;
    localparam logic [2:0] OP_POP1     = 3'd2;
    localparam logic [2:0] OP_POP2     = 3'd3;
    localparam logic [2:0] OP_DUP      = 3'd4;
    localparam logic [2:0] OP_SWAP     = 3'd5;
    localparam logic [2:0] OP_POP2PUSH = 3'd6;

    localparam logic [1:0] SRC_ZERO = 2'd0;
    localparam logic [1:0] SRC_IN   = 2'd1;
    localparam logic [1:0] SRC_MEM  = 2'd2;
    localparam logic [1:0] SRC_REG  = 2'd3;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MEMWAIT = 1'b1;

    // Occupancy after an op; saturates at 0 and DEPTH so the reported depth
    // stays meaningful even when the pointer is allowed to wrap.
    function automatic logic [CW-1:0] sat_step(input logic [CW-1:0] c, input logic [2:0] o);
        logic [CW-1:0] r;
        r = c;
        case (o)
            OP_PUSH, OP_DUP: r = (c == DEPTH_C) ? c : c + CW'(1);
            OP_POP1:         r = (c == '0) ? '0 : c - CW'(1);
            OP_POP2:         r = (c < CW'(2)) ? '0 : c - CW'(2);
            OP_POP2PUSH:     r = (c < CW'(2)) ? CW'(1) : c - CW'(1);
            default:         r = c;
        endcase
        return r;
    endfunction

    logic [0:0]        state_q;
    logic [2:0]        pend_op_q;
    logic [AW-1:0]     ptr_q;
    logic [CW-1:0]     cnt_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              err_q;

    logic [DATA_W-1:0] stk  [DEPTH];
    logic [DATA_W-1:0] regs [NREGS];

    logic              accept;
    logic              trap;
    logic [DATA_W-1:0] src_val;
    logic              exec_en;
    logic [2:0]        exec_op;
    logic [DATA_W-1:0] exec_val;
    logic              go_wait;
    logic              set_err;

    logic [AW-1:0]     ptr_n;
    logic [CW-1:0]     cnt_n;
    logic [DATA_W-1:0] a_raw;
    logic [DATA_W-1:0] b_raw;
    logic [DATA_W-1:0] a_n;
    logic [DATA_W-1:0] b_n;
    logic              wr0_en;
    logic [AW-1:0]     wr0_idx;
    logic [DATA_W-1:0] wr0_dat;
    logic              wr1_en;
    logic [AW-1:0]     wr1_idx;
    logic [DATA_W-1:0] wr1_dat;

    assign accept = op_valid && (state_q == ST_IDLE);

`ifdef STACK_ERR_TRAP_EN
    // Minimum occupancy an op needs before it can run without underflow.
    function automatic logic [CW-1:0] need_of(input logic [2:0] o);
        logic [CW-1:0] r;
        case (o)
            OP_POP1, OP_DUP:               r = CW'(1);
            OP_POP2, OP_SWAP, OP_POP2PUSH: r = CW'(2);
            default:                       r = '0;
        endcase
        return r;
    endfunction

    assign trap = (cnt_q < need_of(op)) ||
                  (((op == OP_PUSH) || (op == OP_DUP)) && (cnt_q == DEPTH_C));
`else
    // Wrapping build: nothing is ever trapped, so err_q can never set.
    assign trap = 1'b0;
`endif

    // Push operand selection; the register file is read combinationally so a
    // same-cycle reg_we still sees the old contents.
    always_comb begin
        src_val = '0;
        case (push_src)
            SRC_ZERO: src_val = '0;
            SRC_IN:   src_val = push_in;
            SRC_REG:  src_val = regs[reg_addr];
            default:  src_val = '0;
        endcase
    end

    // Decide what (if anything) executes this cycle: an accepted op, a trap,
    // entry to MEMWAIT, or completion of the pending memory push.
    always_comb begin
        exec_en  = 1'b0;
        exec_op  = op;
        exec_val = src_val;
        go_wait  = 1'b0;
        set_err  = 1'b0;
        if (state_q == ST_MEMWAIT) begin
            exec_en  = 1'b1;
            exec_op  = pend_op_q;
            exec_val = mem_rdata;
        end else if (accept) begin
            if (trap) begin
                set_err = 1'b1;
            end else if (((op == OP_PUSH) || (op == OP_POP2PUSH)) && (push_src == SRC_MEM)) begin
                go_wait = 1'b1;
            end else begin
                exec_en = 1'b1;
            end
        end
    end

    // Next stack pointer, occupancy, head registers and array writes.
    // ptr_q points at the next free slot, so the top entry lives at ptr_q-1.
    always_comb begin
        ptr_n   = ptr_q;
        cnt_n   = cnt_q;
        a_raw   = a_q;
        b_raw   = b_q;
        wr0_en  = 1'b0;
        wr0_idx = ptr_q;
        wr0_dat = exec_val;
        wr1_en  = 1'b0;
        wr1_idx = ptr_q - AW'(2);
        wr1_dat = a_q;
        if (exec_en) begin
            cnt_n = sat_step(cnt_q, exec_op);
            case (exec_op)
                OP_PUSH, OP_DUP: begin
                    wr0_en  = 1'b1;
                    wr0_idx = ptr_q;
                    wr0_dat = (exec_op == OP_DUP) ? a_q : exec_val;
                    ptr_n   = ptr_q + AW'(1);
                    a_raw   = wr0_dat;
                    b_raw   = a_q;
                end
                OP_POP1: begin
                    ptr_n = ptr_q - AW'(1);
                    a_raw = b_q;
                    b_raw = stk[ptr_q - AW'(3)];
                end
                OP_POP2: begin
                    ptr_n = ptr_q - AW'(2);
                    a_raw = stk[ptr_q - AW'(3)];
                    b_raw = stk[ptr_q - AW'(4)];
                end
                OP_SWAP: begin
                    wr0_en  = 1'b1;
                    wr0_idx = ptr_q - AW'(1);
                    wr0_dat = b_q;
                    wr1_en  = 1'b1;
                    wr1_idx = ptr_q - AW'(2);
                    wr1_dat = a_q;
                    a_raw   = b_q;
                    b_raw   = a_q;
                end
                OP_POP2PUSH: begin
                    wr0_en  = 1'b1;
                    wr0_idx = ptr_q - AW'(2);
                    wr0_dat = exec_val;
                    ptr_n   = ptr_q - AW'(1);
                    a_raw   = exec_val;
                    b_raw   = stk[ptr_q - AW'(3)];
                end
                default: begin
                    ptr_n = ptr_q;
                end
            endcase
        end
        a_n = (cnt_n >= CW'(1)) ? a_raw : '0;
        b_n = (cnt_n >= CW'(2)) ? b_raw : '0;
    end

    // Control state, pointer, occupancy, head registers and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pend_op_q <= OP_NOP;
            ptr_q     <= '0;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            err_q     <= 1'b0;
        end else begin
            if (go_wait) begin
                state_q   <= ST_MEMWAIT;
                pend_op_q <= op;
            end else if (state_q == ST_MEMWAIT) begin
                state_q <= ST_IDLE;
            end
            ptr_q <= ptr_n;
            cnt_q <= cnt_n;
            a_q   <= a_n;
            b_q   <= b_n;
            if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

    // Stack body storage; stale contents are masked by the occupancy count.
    always_ff @(posedge clk) begin
        if (wr0_en) begin
            stk[wr0_idx] <= wr0_dat;
        end
        if (wr1_en) begin
            stk[wr1_idx] <= wr1_dat;
        end
    end

    // General register file, written from the current top of stack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_we) begin
            regs[reg_addr] <= a_q;
        end
    end

    assign op_ready  = (state_q == ST_IDLE);
    assign a_out     = a_q;
    assign b_out     = b_q;
    assign depth     = cnt_q;
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == DEPTH_C);
    assign err       = err_q;
    assign mem_addr  = a_q;
    assign mem_wdata = b_q;
    assign mem_wen   = mem_we;

endmodule

// File: tb/tb_stack_core_p.sv
// tb_stack_core_p: directed scenarios plus a randomized run against a
// queue-based stack model.
module tb_stack_core_p;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int NREGS  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              op_valid = 1'b0;
    logic              op_ready;
    logic [2:0]        op = 3'd0;
    logic [1:0]        push_src = 2'd0;
    logic [15:0]       push_in = 16'h0;
    logic [1:0]        reg_addr = 2'd0;
    logic              reg_we = 1'b0;
    logic              mem_we = 1'b0;
    logic [15:0]       mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_wen;
    logic [15:0]       mem_rdata = 16'h0;
    logic [15:0]       a_out;
    logic [15:0]       b_out;
    logic [4:0]        depth;
    logic              empty;
    logic              full;
    logic              err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] q [$];
    logic [15:0] rm [NREGS];

    always #5 clk = ~clk;

    stack_core_p #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NREGS(NREGS)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op(op), .push_src(push_src), .push_in(push_in), .reg_addr(reg_addr),
        .reg_we(reg_we), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wen(mem_wen), .mem_rdata(mem_rdata), .a_out(a_out), .b_out(b_out),
        .depth(depth), .empty(empty), .full(full), .err(err)
    );

    function automatic logic [15:0] exp_a();
        return (q.size() > 0) ? q[q.size()-1] : 16'h0;
    endfunction

    function automatic logic [15:0] exp_b();
        return (q.size() > 1) ? q[q.size()-2] : 16'h0;
    endfunction

    task automatic apply(input logic [2:0] o, input logic [15:0] val);
        logic [15:0] x, y;
        case (o)
            3'd1: q.push_back(val);
            3'd2: x = q.pop_back();
            3'd3: begin x = q.pop_back(); y = q.pop_back(); end
            3'd4: q.push_back(q[q.size()-1]);
            3'd5: begin x = q.pop_back(); y = q.pop_back(); q.push_back(x); q.push_back(y); end
            3'd6: begin x = q.pop_back(); y = q.pop_back(); q.push_back(val); end
            default: ;
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        op_valid = 1'b0; reg_we = 1'b0; mem_we = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        for (int i = 0; i < NREGS; i++) rm[i] = 16'h0;
    endtask

    // One accepted single-cycle op; returns 1 ns after the edge.
    task automatic cyc(input logic [2:0] o, input logic [1:0] s, input logic [15:0] pi,
                       input logic [1:0] ra, input logic rw);
        @(negedge clk);
        op_valid = 1'b1; op = o; push_src = s; push_in = pi; reg_addr = ra; reg_we = rw;
        @(posedge clk);
        #1;
        op_valid = 1'b0; reg_we = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({a_out, b_out, depth, empty, full, err, op_ready} !== {16'h0, 16'h0, 5'd0, 4'b1001}) begin
            n_bad++;
            $display("FAIL reset_state: got a=%h b=%h d=%0d e=%b f=%b err=%b rdy=%b want 0 0 0 1 0 0 1",
                     a_out, b_out, depth, empty, full, err, op_ready);
        end
        cyc(3'd1, 2'd1, 16'h1234, 2'd0, 1'b0);
        cyc(3'd0, 2'd0, 16'h0, 2'd1, 1'b1);
        cyc(3'd1, 2'd3, 16'h0, 2'd1, 1'b0);
        n_cmp++;
        if (a_out !== 16'h1234) begin
            n_bad++;
            $display("FAIL reg_readback: got %h want 1234", a_out);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({a_out, b_out, depth, op_ready} !== {16'h0, 16'h0, 5'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL async_reset: got a=%h b=%h d=%0d rdy=%b want 0 0 0 1", a_out, b_out, depth, op_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        cyc(3'd1, 2'd3, 16'h0, 2'd1, 1'b0);
        n_cmp++;
        if ({a_out, depth} !== {16'h0, 5'd1}) begin
            n_bad++;
            $display("FAIL regfile_cleared: got a=%h d=%0d want 0000 1", a_out, depth);
        end
    endtask

    task automatic test_push_basic();
        do_reset();
        cyc(3'd1, 2'd1, 16'h0011, 2'd0, 1'b0);
        cyc(3'd1, 2'd1, 16'h0022, 2'd0, 1'b0);
        n_cmp++;
        if ({a_out, b_out, depth, empty} !== {16'h0022, 16'h0011, 5'd2, 1'b0}) begin
            n_bad++;
            $display("FAIL push_basic: got a=%h b=%h d=%0d want 0022 0011 2", a_out, b_out, depth);
        end
    endtask

    task automatic test_mem_push();
        do_reset();
        cyc(3'd1, 2'd1, 16'h0005, 2'd0, 1'b0);
        @(negedge clk);
        op_valid = 1'b1; op = 3'd1; push_src = 2'd2; mem_we = 1'b1;
        #1;
        n_cmp++;
        if ({mem_addr, mem_wen} !== {16'h0005, 1'b1}) begin
            n_bad++;
            $display("FAIL mem_addr_accept: got addr=%h wen=%b want 0005 1", mem_addr, mem_wen);
        end
        mem_we = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({op_ready, mem_addr, depth} !== {1'b0, 16'h0005, 5'd1}) begin
            n_bad++;
            $display("FAIL memwait: got rdy=%b addr=%h d=%0d want 0 0005 1", op_ready, mem_addr, depth);
        end
        @(negedge clk);
        mem_rdata = 16'hBEEF;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        n_cmp++;
        if ({a_out, b_out, depth, op_ready} !== {16'hBEEF, 16'h0005, 5'd2, 1'b1}) begin
            n_bad++;
            $display("FAIL mem_push: got a=%h b=%h d=%0d rdy=%b want beef 0005 2 1", a_out, b_out, depth, op_ready);
        end
        @(negedge clk);
        op_valid = 1'b1; op = 3'd6; push_src = 2'd2;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        mem_rdata = 16'h1357;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({a_out, b_out, depth, op_ready} !== {16'h1357, 16'h0000, 5'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL mem_pop2push: got a=%h b=%h d=%0d rdy=%b want 1357 0000 1 1", a_out, b_out, depth, op_ready);
        end
    endtask

    task automatic test_swap_pop2push();
        do_reset();
        cyc(3'd1, 2'd1, 16'h0003, 2'd0, 1'b0);
        cyc(3'd1, 2'd1, 16'h0004, 2'd0, 1'b0);
        cyc(3'd5, 2'd0, 16'h0000, 2'd0, 1'b0);
        n_cmp++;
        if ({a_out, b_out, depth} !== {16'h0003, 16'h0004, 5'd2}) begin
            n_bad++;
            $display("FAIL swap: got a=%h b=%h d=%0d want 0003 0004 2", a_out, b_out, depth);
        end
        cyc(3'd6, 2'd1, 16'h0007, 2'd0, 1'b0);
        n_cmp++;
        if ({a_out, b_out, depth} !== {16'h0007, 16'h0000, 5'd1}) begin
            n_bad++;
            $display("FAIL pop2push: got a=%h b=%h d=%0d want 0007 0000 1", a_out, b_out, depth);
        end
    endtask

    task automatic test_reg_bypass();
        do_reset();
        cyc(3'd1, 2'd1, 16'h00AA, 2'd0, 1'b0);
        cyc(3'd1, 2'd3, 16'h0000, 2'd2, 1'b1);
        n_cmp++;
        if ({a_out, b_out, depth} !== {16'h0000, 16'h00AA, 5'd2}) begin
            n_bad++;
            $display("FAIL reg_same_cycle: got a=%h b=%h d=%0d want 0000 00aa 2", a_out, b_out, depth);
        end
        cyc(3'd1, 2'd3, 16'h0000, 2'd2, 1'b0);
        n_cmp++;
        if ({a_out, depth} !== {16'h00AA, 5'd3}) begin
            n_bad++;
            $display("FAIL reg_next: got a=%h d=%0d want 00aa 3", a_out, depth);
        end
    endtask

    task automatic test_overflow_underflow();
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(3'd1, 2'd1, 16'(i + 1), 2'd0, 1'b0);
        n_cmp++;
        if ({full, err, depth} !== {1'b1, 1'b0, 5'd16}) begin
            n_bad++;
            $display("FAIL fill: got full=%b err=%b d=%0d want 1 0 16", full, err, depth);
        end
        cyc(3'd1, 2'd1, 16'(DEPTH + 1), 2'd0, 1'b0);
`ifdef STACK_ERR_TRAP_EN
        n_cmp++;
        if ({full, err, depth, a_out, b_out} !== {1'b1, 1'b1, 5'd16, 16'd16, 16'd15}) begin
            n_bad++;
            $display("FAIL overflow_trap: got full=%b err=%b d=%0d a=%h b=%h want 1 1 16 0010 000f",
                     full, err, depth, a_out, b_out);
        end
`else
        n_cmp++;
        if ({full, err, depth, a_out, b_out} !== {1'b1, 1'b0, 5'd16, 16'd17, 16'd16}) begin
            n_bad++;
            $display("FAIL overflow_wrap: got full=%b err=%b d=%0d a=%h b=%h want 1 0 16 0011 0010",
                     full, err, depth, a_out, b_out);
        end
`endif
        do_reset();
        #1;
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clear: got %b want 0", err);
        end
        cyc(3'd2, 2'd0, 16'h0, 2'd0, 1'b0);
`ifdef STACK_ERR_TRAP_EN
        n_cmp++;
        if ({depth, empty, err, a_out} !== {5'd0, 1'b1, 1'b1, 16'h0}) begin
            n_bad++;
            $display("FAIL underflow_trap: got d=%0d e=%b err=%b a=%h want 0 1 1 0000", depth, empty, err, a_out);
        end
`else
        n_cmp++;
        if ({depth, empty, err, a_out} !== {5'd0, 1'b1, 1'b0, 16'h0}) begin
            n_bad++;
            $display("FAIL underflow_wrap: got d=%0d e=%b err=%b a=%h want 0 1 0 0000", depth, empty, err, a_out);
        end
`endif
    endtask

    task automatic test_reset_memwait();
        do_reset();
        cyc(3'd1, 2'd1, 16'h0005, 2'd0, 1'b0);
        @(negedge clk);
        op_valid = 1'b1; op = 3'd1; push_src = 2'd2;
        @(posedge clk);
        #1;
        n_cmp++;
        if (op_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_memwait_enter: got rdy=%b want 0", op_ready);
        end
        @(negedge clk);
        op_valid = 1'b0;
        reset = 1'b1;
        mem_rdata = 16'hBEEF;
        #1;
        n_cmp++;
        if ({depth, op_ready, a_out} !== {5'd0, 1'b1, 16'h0}) begin
            n_bad++;
            $display("FAIL rst_memwait_now: got d=%0d rdy=%b a=%h want 0 1 0000", depth, op_ready, a_out);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({depth, op_ready, a_out} !== {5'd0, 1'b1, 16'h0}) begin
            n_bad++;
            $display("FAIL rst_memwait_after: got d=%0d rdy=%b a=%h want 0 1 0000", depth, op_ready, a_out);
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [1:0]  s, ra;
        logic [15:0] pi, pv, md;
        logic        rw, mw, v, grow;
        int          need;
        do_reset();
        for (int it = 0; it < 600; it++) begin
            @(negedge clk);
            n_cmp++;
            if ({a_out, b_out, depth, empty, full, err, op_ready} !==
                {exp_a(), exp_b(), 5'(q.size()), (q.size() == 0), (q.size() == DEPTH), 1'b0, 1'b1}) begin
                n_bad++;
                $display("FAIL rand_state it=%0d: got a=%h b=%h d=%0d e=%b f=%b err=%b rdy=%b want a=%h b=%h d=%0d",
                         it, a_out, b_out, depth, empty, full, err, op_ready, exp_a(), exp_b(), q.size());
            end
            v    = ($urandom_range(0, 7) != 0);
            o    = 3'($urandom_range(0, 7));
            need = (o == 3'd2 || o == 3'd4) ? 1 : (o == 3'd3 || o == 3'd5 || o == 3'd6) ? 2 : 0;
            grow = (o == 3'd1 || o == 3'd4);
            if (q.size() < need || (grow && q.size() == DEPTH)) o = 3'd0;
            s  = 2'($urandom_range(0, 3));
            pi = 16'($urandom);
            ra = 2'($urandom_range(0, 3));
            rw = ($urandom_range(0, 3) == 0);
            mw = 1'($urandom_range(0, 1));
            md = 16'($urandom);
            op_valid = v; op = o; push_src = s; push_in = pi;
            reg_addr = ra; reg_we = rw; mem_we = mw; mem_rdata = md;
            #1;
            n_cmp++;
            if ({mem_addr, mem_wdata, mem_wen} !== {exp_a(), exp_b(), mw}) begin
                n_bad++;
                $display("FAIL rand_memport it=%0d: got %h %h %b want %h %h %b",
                         it, mem_addr, mem_wdata, mem_wen, exp_a(), exp_b(), mw);
            end
            @(posedge clk);
            pv = (s == 2'd1) ? pi : (s == 2'd3) ? rm[ra] : 16'h0;
            if (rw) rm[ra] = exp_a();
            if (v && (o == 3'd1 || o == 3'd6) && s == 2'd2) begin
                @(negedge clk);
                n_cmp++;
                if ({op_ready, a_out, depth} !== {1'b0, exp_a(), 5'(q.size())}) begin
                    n_bad++;
                    $display("FAIL rand_memwait it=%0d: got rdy=%b a=%h d=%0d want 0 %h %0d",
                             it, op_ready, a_out, depth, exp_a(), q.size());
                end
                md = 16'($urandom);
                ra = 2'($urandom_range(0, 3));
                rw = ($urandom_range(0, 3) == 0);
                mem_rdata = md; reg_addr = ra; reg_we = rw;
                @(posedge clk);
                if (rw) rm[ra] = exp_a();
                apply(o, md);
            end else if (v) begin
                apply(o, pv);
            end
        end
        @(negedge clk);
        op_valid = 1'b0; reg_we = 1'b0; mem_we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_push_basic();
        test_mem_push();
        test_swap_pop2push();
        test_reg_bypass();
        test_overflow_underflow();
        test_reset_memwait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
